// File: rtl/gemm_pkg.sv
// Shared widths, derived tile constants, FSM states and word helpers
// for the tiled int8 GEMM engine.
package gemm_pkg;

  localparam int DATA_W    = 8;
  localparam int PSUM_W    = 32;
  localparam int PE_N      = 14;
  localparam int SLICE_IDX = 32;
  localparam int OUT_CH_N  = 64;
  localparam int K         = 294;
  localparam int COL_N     = 70;

  localparam int M0_DEPTH = 4116;
  localparam int M0_AW    = 13;
  localparam int M1_DEPTH = 1470;
  localparam int M1_AW    = 11;
  localparam int M2_DEPTH = 896;
  localparam int M2_AW    = 10;

  localparam int WORD_W  = PE_N * DATA_W;
  localparam int M_TILES = M0_DEPTH / K;
  localparam int N_TILES = COL_N / PE_N;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    WRITE,
    NEXT,
    DONE
  } state_e;

  // Element 0 lives in the MSBs of a memory word.
  function automatic logic [DATA_W-1:0] get_elem(
    input logic [WORD_W-1:0] w,
    input int                e
  );
    return w[WORD_W-1-e*DATA_W -: DATA_W];
  endfunction

  function automatic logic [WORD_W-1:0] put_elem(
    input logic [WORD_W-1:0] w,
    input int                e,
    input logic [DATA_W-1:0] v
  );
    logic [WORD_W-1:0] r;
    r = w;
    r[WORD_W-1-e*DATA_W -: DATA_W] = v;
    return r;
  endfunction

endpackage

// File: rtl/gemm_mac_pe.sv
// Single signed multiply-accumulate cell with synchronous clear
// and enable; the accumulator wraps at PSUM_WIDTH.
module gemm_mac_pe #(
  parameter int DATA_WIDTH = 8,
  parameter int PSUM_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [PSUM_WIDTH-1:0] acc
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [PW-1:0]         prod;
  logic [PSUM_WIDTH-1:0] prod_x;

  assign prod   = PW'($signed(a) * $signed(b));
  assign prod_x = {{(PSUM_WIDTH-PW){prod[PW-1]}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_x;
    end
  end

endmodule

// File: rtl/gemm_tile_engine.sv
// Tiled int8 GEMM: streams ifmap/weight BRAMs into a PE_SIZE^2 MAC array
// and writes sliced results to the ofmap BRAM. Optional ReLU: GEMM_RELU_EN.
module gemm_tile_engine
  import gemm_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_W,
  parameter int PSUM_WIDTH      = PSUM_W,
  parameter int PE_SIZE         = PE_N,
  parameter int SLICING_IDX     = SLICE_IDX,
  parameter int OUT_CH          = OUT_CH_N,
  parameter int WEIGHT_ROW_NUM  = K,
  parameter int WEIGHT_COL_NUM  = COL_N,
  parameter int MEM0_DEPTH      = M0_DEPTH,
  parameter int MEM0_DATA_WIDTH = WORD_W,
  parameter int MEM0_ADDR_WIDTH = M0_AW,
  parameter int MEM1_DEPTH      = M1_DEPTH,
  parameter int MEM1_DATA_WIDTH = WORD_W,
  parameter int MEM1_ADDR_WIDTH = M1_AW,
  parameter int MEM2_DEPTH      = M2_DEPTH,
  parameter int MEM2_DATA_WIDTH = WORD_W,
  parameter int MEM2_ADDR_WIDTH = M2_AW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       gemm_start_i,
  output logic                       mem0_ce0,
  output logic                       mem0_we0,
  output logic [MEM0_ADDR_WIDTH-1:0] mem0_addr0,
  input  logic [MEM0_DATA_WIDTH-1:0] mem0_q0_i,
  output logic                       mem1_ce0,
  output logic                       mem1_we0,
  output logic [MEM1_ADDR_WIDTH-1:0] mem1_addr0,
  input  logic [MEM1_DATA_WIDTH-1:0] mem1_q0_i,
  output logic                       mem2_ce0,
  output logic                       mem2_we0,
  output logic [MEM2_ADDR_WIDTH-1:0] mem2_addr0,
  output logic [MEM2_DATA_WIDTH-1:0] mem2_d0,
  output logic                       finish_o
);

  localparam int KN  = WEIGHT_ROW_NUM;
  localparam int MT  = MEM0_DEPTH / KN;
  localparam int NT  = WEIGHT_COL_NUM / PE_SIZE;
  localparam int CW  = $clog2(KN + 1);
  localparam int MW  = $clog2(MT + 1);
  localparam int NW  = $clog2(NT + 1);
  localparam int CIW = $clog2(PE_SIZE);

  state_e state, state_nx;

  logic [CW-1:0]  cnt;
  logic [MW-1:0]  m;
  logic [NW-1:0]  n;
  logic [CIW-1:0] col;
  logic           rd_vld;
  logic           clr_acc;
  logic           last_k;
  logic           last_c;
  logic           last_m;
  logic           last_n;

  logic [DATA_WIDTH-1:0] a_el [PE_SIZE];
  logic [DATA_WIDTH-1:0] b_el [PE_SIZE];
  logic [PSUM_WIDTH-1:0] acc  [PE_SIZE][PE_SIZE];

  assign col    = cnt[CIW-1:0];
  assign last_k = (cnt == CW'(KN - 1));
  assign last_c = (cnt == CW'(PE_SIZE - 1));
  assign last_m = (m == MW'(MT - 1));
  assign last_n = (n == NW'(NT - 1));

  function automatic logic [DATA_WIDTH-1:0] out_byte(
    input logic [PSUM_WIDTH-1:0] x
  );
    logic [PSUM_WIDTH-1:0] v;
    v = x;
`ifdef GEMM_RELU_EN
    if (v[PSUM_WIDTH-1]) v = '0;
`endif
    return v[SLICING_IDX-1 -: DATA_WIDTH];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (gemm_start_i) state_nx = READ;
      READ:  if (last_k) state_nx = DRAIN;
      DRAIN: state_nx = WRITE;
      WRITE: if (last_c) state_nx = NEXT;
      NEXT:  state_nx = (last_m && last_n) ? DONE : READ;
      DONE:  if (!gemm_start_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Read data lags the address by one cycle, so MAC enable does too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      m      <= '0;
      n      <= '0;
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= (state == READ);
      unique case (state)
        IDLE: begin
          cnt <= '0;
          m   <= '0;
          n   <= '0;
        end
        READ:  cnt <= last_k ? '0 : cnt + 1'b1;
        DRAIN: cnt <= '0;
        WRITE: cnt <= cnt + 1'b1;
        NEXT: begin
          cnt <= '0;
          if (last_n) begin
            n <= '0;
            m <= last_m ? '0 : m + 1'b1;
          end else begin
            n <= n + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    int ch;
    mem0_ce0   = 1'b0;
    mem0_we0   = 1'b0;
    mem0_addr0 = '0;
    mem1_ce0   = 1'b0;
    mem1_we0   = 1'b0;
    mem1_addr0 = '0;
    mem2_ce0   = 1'b0;
    mem2_we0   = 1'b0;
    mem2_addr0 = '0;
    mem2_d0    = '0;
    finish_o   = (state == DONE);
    clr_acc    = (state == IDLE) || (state == NEXT);
    ch         = int'(n) * PE_SIZE + int'(col);
    if (state == READ) begin
      mem0_ce0   = 1'b1;
      mem1_ce0   = 1'b1;
      mem0_addr0 = MEM0_ADDR_WIDTH'(int'(m) * KN + int'(cnt));
      mem1_addr0 = MEM1_ADDR_WIDTH'(int'(n) * KN + int'(cnt));
    end
    // Padded channels beyond OUT_CH are computed but never stored.
    if (state == WRITE && ch < OUT_CH) begin
      mem2_ce0   = 1'b1;
      mem2_we0   = 1'b1;
      mem2_addr0 = MEM2_ADDR_WIDTH'(ch * MT + int'(m));
      for (int p = 0; p < PE_SIZE; p++) begin
        mem2_d0 = put_elem(mem2_d0, p, out_byte(acc[p][col]));
      end
    end
  end

  always_comb begin
    for (int e = 0; e < PE_SIZE; e++) begin
      a_el[e] = get_elem(mem0_q0_i, e);
      b_el[e] = get_elem(mem1_q0_i, e);
    end
  end

  for (genvar p = 0; p < PE_SIZE; p++) begin : g_row
    for (genvar c = 0; c < PE_SIZE; c++) begin : g_col
      gemm_mac_pe #(
        .DATA_WIDTH(DATA_WIDTH),
        .PSUM_WIDTH(PSUM_WIDTH)
      ) u_pe (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr_acc),
        .en   (rd_vld),
        .a    (a_el[p]),
        .b    (b_el[c]),
        .acc  (acc[p][c])
      );
    end
  end

endmodule

// File: tb/tb_gemm_tile_engine.sv
// Directed self-checking bench for gemm_tile_engine with BRAM models
// and SLICING_IDX=8 so the output byte is the low accumulator byte.
module tb_gemm_tile_engine;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         gemm_start_i = 1'b0;
  logic         mem0_ce0, mem0_we0;
  logic [12:0]  mem0_addr0;
  logic [111:0] mem0_q0_i;
  logic         mem1_ce0, mem1_we0;
  logic [10:0]  mem1_addr0;
  logic [111:0] mem1_q0_i;
  logic         mem2_ce0, mem2_we0;
  logic [9:0]   mem2_addr0;
  logic [111:0] mem2_d0;
  logic         finish_o;

  logic [111:0] mem0 [4116];
  logic [111:0] mem1 [1470];
  logic [111:0] mem2 [896];

  int  wr_cnt, max_addr, oob, we_bad;
  bit  clr_stats = 1'b0;
  int  total = 0;
  int  bad = 0;

  logic [152:0] all_out;
  assign all_out = {mem0_ce0, mem0_we0, mem1_ce0, mem1_we0,
                    mem2_ce0, mem2_we0, finish_o,
                    mem0_addr0, mem1_addr0, mem2_addr0, mem2_d0};

  gemm_tile_engine #(.SLICING_IDX(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .gemm_start_i(gemm_start_i),
    .mem0_ce0    (mem0_ce0),
    .mem0_we0    (mem0_we0),
    .mem0_addr0  (mem0_addr0),
    .mem0_q0_i   (mem0_q0_i),
    .mem1_ce0    (mem1_ce0),
    .mem1_we0    (mem1_we0),
    .mem1_addr0  (mem1_addr0),
    .mem1_q0_i   (mem1_q0_i),
    .mem2_ce0    (mem2_ce0),
    .mem2_we0    (mem2_we0),
    .mem2_addr0  (mem2_addr0),
    .mem2_d0     (mem2_d0),
    .finish_o    (finish_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem0_ce0) mem0_q0_i <= mem0[int'(mem0_addr0)];
    if (mem1_ce0) mem1_q0_i <= mem1[int'(mem1_addr0)];
    if (mem0_we0 || mem1_we0) we_bad <= we_bad + 1;
    if (clr_stats) begin
      wr_cnt   <= 0;
      max_addr <= 0;
      oob      <= 0;
      we_bad   <= 0;
      for (int i = 0; i < 896; i++) mem2[i] <= {14{8'h55}};
    end else if (mem2_ce0 && mem2_we0) begin
      wr_cnt <= wr_cnt + 1;
      if (int'(mem2_addr0) > max_addr) max_addr <= int'(mem2_addr0);
      if (int'(mem2_addr0) < 896) mem2[int'(mem2_addr0)] <= mem2_d0;
      else oob <= oob + 1;
    end
  end

  task automatic fill(input logic [111:0] w0, input logic [111:0] w1);
    for (int i = 0; i < 4116; i++) mem0[i] = w0;
    for (int i = 0; i < 1470; i++) mem1[i] = w1;
  endtask

  task automatic do_run(input bit hold, output bit to);
    int cyc;
    clr_stats = 1'b1;
    @(posedge clk);
    #1 clr_stats = 1'b0;
    @(negedge clk);
    gemm_start_i = 1'b1;
    cyc = 0;
    while (finish_o !== 1'b1 && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (!hold && cyc == 50) gemm_start_i = 1'b0;
    end
    to = (finish_o !== 1'b1);
  endtask

  task automatic count_bytes(input logic [7:0] exp, output int nbad);
    logic [111:0] w;
    nbad = 0;
    for (int a = 0; a < 896; a++) begin
      w = mem2[a];
      for (int e = 0; e < 14; e++)
        if (w[111-8*e -: 8] !== exp) nbad++;
    end
  endtask

  task automatic check_stats(input string tag, input bit to);
    total++;
    if (to !== 1'b0) begin
      bad++;
      $display("FAIL %s_timeout finish_o=%b want 1", tag, finish_o);
    end
    total++;
    if (wr_cnt !== 896) begin
      bad++;
      $display("FAIL %s_wr_cnt got=%0d want=896", tag, wr_cnt);
    end
    total++;
    if (oob !== 0) begin
      bad++;
      $display("FAIL %s_oob got=%0d want=0", tag, oob);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (all_out !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", all_out);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (all_out !== '0) begin
      bad++;
      $display("FAIL idle_outputs got=%h want=0", all_out);
    end
  endtask

  task automatic test_all_ones;
    bit to;
    int nb;
    fill({14{8'h01}}, {14{8'h01}});
    do_run(1'b1, to);
    check_stats("ones", to);
    total++;
    if (max_addr !== 895) begin
      bad++;
      $display("FAIL ones_max_addr got=%0d want=895", max_addr);
    end
    total++;
    if (we_bad !== 0) begin
      bad++;
      $display("FAIL ones_rd_we got=%0d want=0", we_bad);
    end
    count_bytes(8'd38, nb);
    total++;
    if (nb !== 0) begin
      bad++;
      $display("FAIL ones_values bad_elems=%0d want=0", nb);
    end
  endtask

  task automatic test_start_hold;
    int drop = 0;
    repeat (5) begin
      @(negedge clk);
      if (finish_o !== 1'b1) drop++;
    end
    total++;
    if (drop !== 0) begin
      bad++;
      $display("FAIL hold_finish low_cycles=%0d want=0", drop);
    end
    gemm_start_i = 1'b0;
    @(negedge clk);
    total++;
    if (finish_o !== 1'b0) begin
      bad++;
      $display("FAIL hold_release finish_o=%b want=0", finish_o);
    end
    @(negedge clk);
    total++;
    if (all_out !== '0) begin
      bad++;
      $display("FAIL hold_idle got=%h want=0", all_out);
    end
  endtask

  task automatic test_single;
    bit to;
    int nb;
    logic [111:0] w;
    fill('0, '0);
    mem0[0] = {8'd2, 104'h0};
    mem1[0] = {8'd3, 104'h0};
    do_run(1'b0, to);
    check_stats("single", to);
    w = mem2[0];
    total++;
    if (w[111:104] !== 8'd6) begin
      bad++;
      $display("FAIL single_elem0 got=%0d want=6", w[111:104]);
    end
    mem2[0][111:104] = 8'd0;
    count_bytes(8'd0, nb);
    total++;
    if (nb !== 0) begin
      bad++;
      $display("FAIL single_rest bad_elems=%0d want=0", nb);
    end
  endtask

  task automatic test_abort_restart;
    bit to;
    int nb;
    logic [7:0] exp;
`ifdef GEMM_RELU_EN
    exp = 8'd0;
`else
    exp = 8'hDA;
`endif
    fill({112{1'b1}}, {14{8'h01}});
    @(negedge clk);
    gemm_start_i = 1'b1;
    repeat (100) @(negedge clk);
    total++;
    if (mem0_ce0 !== 1'b1) begin
      bad++;
      $display("FAIL abort_in_read ce0=%b want=1", mem0_ce0);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (all_out !== '0) begin
      bad++;
      $display("FAIL abort_outputs got=%h want=0", all_out);
    end
    gemm_start_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_run(1'b0, to);
    check_stats("restart", to);
    count_bytes(exp, nb);
    total++;
    if (nb !== 0) begin
      bad++;
      $display("FAIL restart_values bad_elems=%0d want=0 exp=%0d",
               nb, exp);
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_start_hold();
    test_single();
    test_abort_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gemm_tile_engine.md
Name: gemm_tile_engine

Overview:
- Tiled int8 matrix-multiply engine for one conv layer in im2col form: Ofmap[pixel][ch] = sum over k of Ifmap[pixel][k] * Weight[k][ch].
- Streams operands from two external single-cycle-latency BRAMs (mem0 ifmap, mem1 weight), accumulates in a PE_SIZE x PE_SIZE MAC array and writes 8-bit results to a third BRAM (mem2).
- Sits between the BRAM banks and the layer controller, which starts it and waits for finish.

Parameters:
- DATA_WIDTH 8: operand and output element width, signed.
- PSUM_WIDTH 32: accumulator width, signed.
- PE_SIZE 14: MAC array dimension and elements per memory word.
- SLICING_IDX 32: output byte = psum[SLICING_IDX-1 -: DATA_WIDTH].
- OUT_CH 64: real output channels; padded channels are not written.
- WEIGHT_ROW_NUM 294: K, the reduction length.
- WEIGHT_COL_NUM 70: padded channel count, a multiple of PE_SIZE.
- MEM0_DEPTH 4116, MEM0_DATA_WIDTH 112, MEM0_ADDR_WIDTH 13.
- MEM1_DEPTH 1470, MEM1_DATA_WIDTH 112, MEM1_ADDR_WIDTH 11.
- MEM2_DEPTH 896, MEM2_DATA_WIDTH 112, MEM2_ADDR_WIDTH 10.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- gemm_start_i  in  1  level start request.
- mem0_ce0, mem0_we0  out  1  ifmap BRAM enable and write enable; we0 is tied 0.
- mem0_addr0  out  MEM0_ADDR_WIDTH  ifmap address.
- mem0_q0_i  in  MEM0_DATA_WIDTH  ifmap read data.
- mem1_ce0, mem1_we0, mem1_addr0, mem1_q0_i: same roles for the weight BRAM (MEM1 widths).
- mem2_ce0, mem2_we0  out  1  ofmap BRAM enable and write enable.
- mem2_addr0  out  MEM2_ADDR_WIDTH  ofmap address.
- mem2_d0  out  MEM2_DATA_WIDTH  ofmap write data.
- finish_o  out  1  done flag.

Behaviour:
- Derived constants:
  - K = WEIGHT_ROW_NUM.
  - M_TILES = MEM0_DEPTH / K (14).
  - N_TILES = WEIGHT_COL_NUM / PE_SIZE (5).
- Word packing: element 0 occupies the MSBs, i.e. bits [W-1 -: DATA_WIDTH]; element e occupies bits [W-1-e*DATA_WIDTH -: DATA_WIDTH].
- Memory layouts:
  - mem0[m*K + k] = 14 pixels of tile m at reduction index k.
  - mem1[n*K + k] = 14 channels of tile n at index k.
  - mem2[ch*M_TILES + m] = 14 pixels of tile m for channel ch.
- BRAM read latency is 1 cycle: data appears the cycle after ce0 is high with an address.
- FSM states: IDLE, READ, DRAIN, WRITE, NEXT, DONE.
  - IDLE: all ce/we low, finish_o=0, accumulators cleared. gemm_start_i=1 → READ with m=0, n=0.
  - READ: K cycles, ce0=1 on mem0 and mem1, addresses m*K+k and n*K+k, k=0..K-1.
  - MAC array: each cycle the operands arrive, acc[p][c] += sext(ifmap[p]) * sext(weight[c]), full-precision signed, wrapping at PSUM_WIDTH.
  - DRAIN: 1 cycle, absorbs the final read data.
  - WRITE: PE_SIZE cycles, c=0..13, ch=n*PE_SIZE+c.
    - If ch<OUT_CH: mem2_ce0=mem2_we0=1, addr=ch*M_TILES+m, element p of mem2_d0 = out(acc[p][c]).
    - Else: ce0/we0 low, no write.
  - NEXT: clear accumulators. n advances first; on n wrap, m advances. After the last m → DONE, else → READ.
  - DONE: finish_o=1 and held while gemm_start_i=1; when gemm_start_i=0 → IDLE the next cycle, finish_o returns to 0.
- out(x) = x[SLICING_IDX-1 -: DATA_WIDTH]; ReLU is applied first when enabled (see Optional Feature).
- Exactly 896 mem2 writes per run; no address ≥ MEM2_DEPTH is ever issued.
- Run length: about M_TILES*N_TILES*(K+PE_SIZE+2) ≈ 21.7k cycles.
- Reset values: all outputs 0, FSM IDLE, counters 0.
- rst_n asserted mid-run aborts immediately; a new start reruns from tile (0,0).
- gemm_start_i deasserted mid-run is ignored until DONE.

Optional Feature:
- Macro GEMM_RELU_EN.
- Defined: negative accumulators are forced to 0 before slicing.
- Undefined: the raw two's-complement slice is output.

Decomposition:
- Package gemm_pkg: width parameters and derived constants K, M_TILES, N_TILES; FSM state enum; word-element pack/unpack helper functions.
- Sub-module gemm_mac_pe: one signed MAC with synchronous clear and enable, instantiated PE_SIZE² times via generate.

Test Plan:
- All mem0/mem1 elements = 1, SLICING_IDX=8 → every element of every mem2 word = 294 & 0xFF = 38.
- Only mem0[0] elem0 = 2 and mem1[0] elem0 = 3, rest 0, SLICING_IDX=8 → mem2[0] elem0 = 6, all other elements 0.
- Ifmap all -1, weight all 1, SLICING_IDX=8 → with GEMM_RELU_EN all outputs 0; without, all outputs 0xDA (218).
- Weight channels 64-69 nonzero → write count exactly 896, max mem2 address 895, values for channels 0-63 unaffected.
- rst_n pulsed low mid-READ → all ce/we and finish_o 0 immediately; restart yields results identical to a clean run.
- gemm_start_i held high → finish_o stays 1 in DONE; deasserting start drops finish_o the following cycle and the FSM is back in IDLE.
